// File: rtl/data_mem_pkg.sv
// Shared definitions for the data_mem block: access size encodings, the
// controller state enum and a size-to-byte-count helper.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access; the illegal encoding touches none.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_load_ext.sv
// Combinational load formatter: narrows the raw little-endian word to the
// access size and fills the upper bits with zeros or sign copies.
module data_mem_load_ext
  import data_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  // Select width and extension; words pass through untouched.
  always_comb begin
    data = raw;
    case (size)
      SZ_BYTE: data = {{24{sign & raw[7]}}, raw[7:0]};
      SZ_HALF: data = {{16{sign & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable data memory with a valid/ready request port and a
// one-cycle response strobe after WAIT_CYCLES wait states.
// Optional build macro DATA_MEM_ALIGN_CHECK_EN: when defined, misaligned
// half/word accesses are rejected; otherwise they proceed byte-wise.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [7:0]  mem [DEPTH_BYTES];
  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;

  logic        lat_write, lat_sign;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;

  logic        accept;
  logic        cur_write, cur_sign, cur_err;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [2:0]  cur_nbytes;
  logic [32:0] last_byte;
  logic [31:0] raw, fmt_data;

  // Reset wins over a simultaneous request.
  assign accept = req_valid && req_ready && !rst;

  // The access being served: live inputs while idle (acceptance edge),
  // latched copies afterwards.
  always_comb begin
    if (state == IDLE) begin
      cur_write = req_write;
      cur_sign  = req_sign;
      cur_size  = req_size;
      cur_addr  = req_addr;
    end else begin
      cur_write = lat_write;
      cur_sign  = lat_sign;
      cur_size  = lat_size;
      cur_addr  = lat_addr;
    end
  end

  // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    cur_nbytes = size_bytes(cur_size);
    last_byte  = {1'b0, cur_addr} + 33'(cur_nbytes) - 33'd1;
    cur_err    = (cur_size == SZ_BAD) || (last_byte > 33'(DEPTH_BYTES - 1));
`ifdef DATA_MEM_ALIGN_CHECK_EN
    if ((cur_size == SZ_HALF) && cur_addr[0])           cur_err = 1'b1;
    if ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00)) cur_err = 1'b1;
`endif
  end

  // Gather four consecutive bytes little-endian; bytes past the access
  // size are discarded by the formatter.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 4; i++)
      raw[8*i +: 8] = mem[cur_addr[AW-1:0] + AW'(i)];
  end

  data_mem_load_ext u_load_ext (
    .raw  (raw),
    .size (cur_size),
    .sign (cur_sign),
    .data (fmt_data)
  );

  // Store commits at the acceptance edge, only the addressed bytes.
  // NOTE: the storage array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && cur_write && !cur_err)
      for (int i = 0; i < 4; i++)
        if (3'(i) < cur_nbytes)
          mem[cur_addr[AW-1:0] + AW'(i)] <= req_wdata[8*i +: 8];
  end

  // Capture request fields on acceptance for use during wait states.
  // NOTE: data-path registers carry no reset; only control state needs one.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_sign  <= req_sign;
      lat_size  <= req_size;
      lat_addr  <= req_addr;
    end
  end

  // State register and wait counter.
  // NOTE: sequential state always uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt == WAIT_LAST) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // Load data is sampled on the edge entering RESP and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (state_nxt == RESP) begin
      resp_err   <= cur_err;
      resp_rdata <= (cur_err || cur_write) ? '0 : fmt_data;
    end
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH_BYTES, default 256: byte-addressable storage size; power of two, 4..2^20.
REQ-002 Parameter WAIT_CYCLES, default 0: extra wait states per access; 0..15.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_write  input  1  1 store, 0 load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-009 req_sign  input  1  load extension: 1 sign, 0 zero.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, little-endian, low bytes used for byte/half.
REQ-012 resp_valid  output  1  one-cycle response strobe.
REQ-013 resp_rdata  output  32  formatted load data, 0 for stores and errors.
REQ-014 resp_err  output  1  access rejected.

Function
REQ-015 Handshake: request accepted at a posedge with req_valid && req_ready; all req_* fields latched then.
REQ-016 req_ready SHALL be 1 only in state IDLE.
REQ-017 States: IDLE -> WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0) on acceptance; WAIT -> RESP after exactly WAIT_CYCLES cycles; RESP -> IDLE next cycle.
REQ-018 Latency: resp_valid high for exactly one cycle, WAIT_CYCLES+1 cycles after the acceptance edge; back-to-back requests SHALL have a minimum spacing of WAIT_CYCLES+2 cycles.
REQ-019 Little-endian: byte at addr is bits 7:0, addr+1 bits 15:8, etc.
REQ-020 Store commits at the acceptance edge, writing 1/2/4 bytes per req_size; no other bytes change.
REQ-021 Load data sampled at the edge entering RESP, so a load following a store observes the stored data.
REQ-022 Load formatting: byte fills 7:0, half fills 15:0; upper bits are copies of the top loaded bit if req_sign=1, else 0; word ignores req_sign.
REQ-023 Error when req_size=11, or addr+nbytes-1 > DEPTH_BYTES-1 (computed 33-bit, no wrap); erroneous store SHALL NOT modify memory; response carries err=1, rdata=0.
REQ-024 resp_rdata and resp_err SHALL hold their value outside resp_valid cycles until the next response.

Reset
REQ-025 rst sampled high: state IDLE, wait counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready 1 from the first cycle after rst falls.
REQ-026 Memory contents SHALL NOT be reset; a store accepted before rst mid-operation remains committed; its response is dropped.
REQ-027 rst overrides a simultaneous req_valid; no request is accepted in a reset cycle.

Configuration
REQ-028 Macro DATA_MEM_ALIGN_CHECK_EN defined: half at odd address or word at addr[1:0]!=0 SHALL produce err=1 per REQ-023 with no memory change.
REQ-029 Macro undefined: misaligned accesses SHALL proceed byte-wise at addr..addr+nbytes-1, erroring only per REQ-023.

Structure
REQ-030 Package data_mem_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum (IDLE, WAIT, RESP).
REQ-031 Sub-module data_mem_load_ext SHALL perform combinational load size/sign formatting.

Verification
REQ-032 WAIT_CYCLES=0: word store 0xF00FF176 @200, then word load @200 -> resp_valid 1 cycle after each acceptance, rdata 0xF00FF176, err 0.
REQ-033 After REQ-032 data: half load @200 sign=1 -> 0xFFFFF176; sign=0 -> 0x0000F176; byte load @203 sign=1 -> 0xFFFFFFF0.
REQ-034 DEPTH_BYTES=256: word store @254 -> err 1, rdata 0; bytes 252..255 unchanged on readback.
REQ-035 With DATA_MEM_ALIGN_CHECK_EN: word load @201 -> err 1; without: returns bytes 201..204 assembled little-endian, err 0.
REQ-036 WAIT_CYCLES=3: load accepted at cycle t -> resp_valid only at t+4; req_ready low t+1..t+4; rst asserted at t+2 -> no resp_valid, req_ready 1 after rst falls.
